// File: rtl/bram_portb_arbiter.sv
// Round-robin arbiter that time-shares one BRAM port B among NREQ requesters.
// Ports: s_axi_aclk/s_axi_areset (async, active-high), per-requester
//   req/req_we/req_addr/req_wdata in, gnt/rvalid out, shared rdata out,
//   BRAM_PORTB_* to the memory. Build macro BRAM_ARB_STATS_EN adds
//   stat_sel/stat_cnt: saturating accepted-beat counters per requester.
module bram_portb_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                 s_axi_aclk,
  input  logic                 s_axi_areset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*10-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [31:0]          rdata,
  output logic                 BRAM_PORTB_en,
  output logic [3:0]           BRAM_PORTB_we,
  output logic [9:0]           BRAM_PORTB_addr,
  output logic [31:0]          BRAM_PORTB_din,
`ifdef BRAM_ARB_STATS_EN
  input  logic [2:0]           stat_sel,
  output logic [15:0]          stat_cnt,
`endif
  input  logic [31:0]          BRAM_PORTB_dout
);

  localparam int            IW    = $clog2(NREQ);
  localparam logic [IW-1:0] LAST  = IW'(NREQ - 1);
  localparam logic [7:0]    BURST = 8'(MAX_BURST);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t          r_state, w_state;
  logic [IW-1:0]   r_owner, w_owner;
  logic [IW-1:0]   r_rr_ptr, w_rr_ptr;
  logic [7:0]      r_beat_cnt, w_beat_cnt;
  logic [IW-1:0]   w_win, w_owner_inc;
  logic            w_found, w_acc, w_we;
  logic [9:0]      w_addr;
  logic [31:0]     w_din;
  logic [IW-1:0]   r_pb_tag;
  logic [RD_LAT-1:0] r_pv;
  logic [IW-1:0]   r_ptag [RD_LAT];
  logic [31:0]     r_rdata;

  assign w_acc       = (r_state == S_OWN) && req[r_owner];
  assign w_owner_inc = (r_owner == LAST) ? '0 : r_owner + 1'b1;
  assign w_we        = req_we[r_owner];
  assign w_addr      = req_addr[int'(r_owner)*10 +: 10];
  assign w_din       = req_wdata[int'(r_owner)*32 +: 32];

  // first set request at or after rr_ptr, wrapping
  always_comb begin
    logic [IW-1:0] cand;
    cand    = r_rr_ptr;
    w_found = 1'b0;
    w_win   = r_rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_found && req[cand]) begin
        w_found = 1'b1;
        w_win   = cand;
      end
    end
  end

  always_comb begin
    w_state    = r_state;
    w_owner    = r_owner;
    w_rr_ptr   = r_rr_ptr;
    w_beat_cnt = r_beat_cnt;
    gnt        = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state    = S_OWN;
          w_owner    = w_win;
          w_beat_cnt = '0;
        end
      end
      S_OWN: begin
        gnt[r_owner] = req[r_owner];
        if (w_acc)
          w_beat_cnt = r_beat_cnt + 8'd1;
        if (!w_acc || w_beat_cnt == BURST) begin
          w_state  = S_IDLE;
          w_rr_ptr = w_owner_inc;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state;
      r_owner    <= w_owner;
      r_rr_ptr   <= w_rr_ptr;
      r_beat_cnt <= w_beat_cnt;
    end
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      BRAM_PORTB_en   <= 1'b0;
      BRAM_PORTB_we   <= '0;
      BRAM_PORTB_addr <= '0;
      BRAM_PORTB_din  <= '0;
      r_pb_tag        <= '0;
    end else begin
      BRAM_PORTB_en <= w_acc;
      if (w_acc) begin
        BRAM_PORTB_we   <= {4{w_we}};
        BRAM_PORTB_addr <= w_addr;
        BRAM_PORTB_din  <= w_din;
        r_pb_tag        <= r_owner;
      end
    end
  end

  // Read tag/valid pipeline: fed by the port-B issue register so the tail
  // lines up with BRAM_PORTB_dout RD_LAT cycles later.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_pv    <= '0;
      r_rdata <= '0;
      for (int k = 0; k < RD_LAT; k++)
        r_ptag[k] <= '0;
    end else begin
      r_pv[0]   <= BRAM_PORTB_en && (BRAM_PORTB_we == 4'b0000);
      r_ptag[0] <= r_pb_tag;
      for (int k = 1; k < RD_LAT; k++) begin
        r_pv[k]   <= r_pv[k-1];
        r_ptag[k] <= r_ptag[k-1];
      end
      if (r_pv[RD_LAT-1])
        r_rdata <= BRAM_PORTB_dout;
    end
  end

  always_comb begin
    rvalid = '0;
    if (r_pv[RD_LAT-1])
      rvalid[r_ptag[RD_LAT-1]] = 1'b1;
  end

  // pass dout through on the strobe, otherwise hold the last returned word
  assign rdata = r_pv[RD_LAT-1] ? BRAM_PORTB_dout : r_rdata;

`ifdef BRAM_ARB_STATS_EN
  logic [15:0] r_stat [NREQ];

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      for (int k = 0; k < NREQ; k++)
        r_stat[k] <= '0;
    end else if (w_acc && r_stat[r_owner] != 16'hFFFF) begin
      r_stat[r_owner] <= r_stat[r_owner] + 16'd1;
    end
  end

  assign stat_cnt = (int'(stat_sel) < NREQ) ? r_stat[stat_sel[IW-1:0]] : 16'd0;
`endif

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Self-checking bench for bram_portb_arbiter with a behavioural BRAM and
// a transaction-level reference model for port B and read returns.
module tb_bram_portb_arbiter;

  localparam int NREQ      = 4;
  localparam int MAX_BURST = 2;
  localparam int RD_LAT    = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   req_we = '0;
  logic [NREQ*10-1:0] req_addr = '0;
  logic [NREQ*32-1:0] req_wdata = '0;
  logic [NREQ-1:0]   gnt, rvalid;
  logic [31:0]       rdata;
  logic              pb_en;
  logic [3:0]        pb_we;
  logic [9:0]        pb_addr;
  logic [31:0]       pb_din;
  logic [31:0]       pb_dout = '0;
`ifdef BRAM_ARB_STATS_EN
  logic [2:0]        stat_sel = '0;
  logic [15:0]       stat_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] pat     [5] = '{32'h1111_fade, 32'h2222_beef, 32'h3333_cafe,
                              32'h4444_feed, 32'h5555_f00d};

  bram_portb_arbiter #(
    .NREQ(NREQ), .MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT)
  ) dut (
    .s_axi_aclk(clk),
    .s_axi_areset(rst),
    .req(req),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .gnt(gnt),
    .rvalid(rvalid),
    .rdata(rdata),
    .BRAM_PORTB_en(pb_en),
    .BRAM_PORTB_we(pb_we),
    .BRAM_PORTB_addr(pb_addr),
    .BRAM_PORTB_din(pb_din),
`ifdef BRAM_ARB_STATS_EN
    .stat_sel(stat_sel),
    .stat_cnt(stat_cnt),
`endif
    .BRAM_PORTB_dout(pb_dout)
  );

  always #5 clk = ~clk;

  // one-cycle-latency, read-first BRAM
  always @(posedge clk) begin
    if (pb_en) begin
      if (pb_we == 4'hF) mem[pb_addr] <= pb_din;
      pb_dout <= mem[pb_addr];
    end
  end

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic r, input logic w,
                         input logic [9:0] a, input logic [31:0] d);
    req[i]             = r;
    req_we[i]          = w;
    req_addr[i*10+:10] = a;
    req_wdata[i*32+:32] = d;
  endtask

  task automatic do_reset();
    drv();
    rst = 1'b1;
    req = '0;
    drv();
    drv();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    drv();
    smp();
    n_checks += 4;
    if (gnt !== 4'b0 || rvalid !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_gnt_rvalid: got %b/%b required 0/0", gnt, rvalid);
    end
    if (rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h required 0", rdata);
    end
    if (pb_en !== 1'b0 || pb_we !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_en_we: got %b/%h required 0/0", pb_en, pb_we);
    end
    if (pb_addr !== 10'h0 || pb_din !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_addr_din: got %h/%h required 0/0", pb_addr, pb_din);
    end
    drv();
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    set_req(0, 1'b1, 1'b1, 10'h005, 32'h0000abcd);
    smp();
    n_checks++;
    if (gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL write_cycle0_gnt: got %b required 0000", gnt);
    end
    drv();
    smp();
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL write_cycle1_gnt: got %b required 0001", gnt);
    end
    drv();
    req[0] = 1'b0;
    smp();
    n_checks++;
    if ({pb_en, pb_we, pb_addr, pb_din} !== {1'b1, 4'hF, 10'h005, 32'h0000abcd}) begin
      n_fail++;
      $display("FAIL write_portb: got en=%b we=%h addr=%h din=%h required 1 f 005 0000abcd",
               pb_en, pb_we, pb_addr, pb_din);
    end
  endtask

  task automatic test_read_latency();
    int g = -1;
    int np = 0;
    int pc = -1;
    logic [31:0] pd = '0;
    logic [3:0]  pv = '0;
    drv();
    drv();
    set_req(1, 1'b1, 1'b0, 10'h005, 32'h0);
    for (int c = 0; c < 12; c++) begin
      smp();
      if (g < 0 && gnt[1] && req[1]) g = c;
      if (rvalid !== 4'b0) begin
        np++;
        pc = c;
        pd = rdata;
        pv = rvalid;
      end
      drv();
      if (c == g) req[1] = 1'b0;
    end
    smp();
    n_checks += 4;
    if (g < 0) begin
      n_fail++;
      $display("FAIL rdlat_grant: got no grant required grant within 12 cycles");
    end
    if (np != 1 || pv !== 4'b0010) begin
      n_fail++;
      $display("FAIL rdlat_pulses: got %0d pulses rvalid=%b required 1 pulse 0010", np, pv);
    end
    if (pc != g + 1 + RD_LAT || pd !== 32'h0000abcd) begin
      n_fail++;
      $display("FAIL rdlat_timing: got cycle %0d data %h required cycle %0d data 0000abcd",
               pc, pd, g + 1 + RD_LAT);
    end
    if (rdata !== 32'h0000abcd) begin
      n_fail++;
      $display("FAIL rdata_hold: got %h required 0000abcd", rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_q [$];
    exp_q.push_back(4'b0000);
    for (int k = 0; k < 5; k++) begin
      for (int b = 0; b < MAX_BURST; b++) exp_q.push_back(4'b0001 << (k % 4));
      if (k < 4) exp_q.push_back(4'b0000);
    end
    do_reset();
    for (int i = 0; i < NREQ; i++)
      set_req(i, 1'b1, 1'b1, 10'(10'h3f0 + i), $urandom);
    for (int c = 0; c < exp_q.size(); c++) begin
      smp();
      n_checks++;
      if (gnt !== exp_q[c]) begin
        n_fail++;
        $display("FAIL rr_cycle%0d: got gnt=%b required %b", c, gnt, exp_q[c]);
      end
      drv();
    end
    req = '0;
    drv();
    drv();
    drv();
  endtask

  task automatic test_back_to_back();
    int due [$];
    logic [31:0] dat [$];
    int idx = 0;
    int np = 0;
    int bad = 0;
    for (int i = 0; i < 5; i++) mem[i] = pat[i];
    set_req(2, 1'b1, 1'b0, 10'h000, 32'h0);
    for (int c = 0; c < 40; c++) begin
      smp();
      if (rvalid !== 4'b0) begin
        np++;
        if (due.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra: got rvalid=%b at cycle %0d required none", rvalid, c);
        end else begin
          if (c != due[0] || rvalid !== 4'b0100 || rdata !== dat[0]) begin
            bad++;
            $display("FAIL b2b_beat: got cycle %0d rvalid=%b data %h required cycle %0d 0100 %h",
                     c, rvalid, rdata, due[0], dat[0]);
          end
          void'(due.pop_front());
          void'(dat.pop_front());
        end
      end
      if (idx < 5 && gnt[2] && req[2]) begin
        due.push_back(c + 1 + RD_LAT);
        dat.push_back(pat[idx]);
        idx++;
      end
      drv();
      if (idx == 5) req[2] = 1'b0;
      else req_addr[20+:10] = 10'(idx);
    end
    n_checks += 2;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL b2b_data: got %0d bad pulses required 0", bad);
    end
    if (np != 5 || idx != 5) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d pulses %0d beats required 5 5", np, idx);
    end
  endtask

  task automatic test_drop();
    int n0 = 0;
    int b1 = 0;
    int b2 = 0;
    do_reset();
    set_req(0, 1'b1, 1'b1, 10'h100, 32'hdead_0000);
    set_req(1, 1'b1, 1'b1, 10'h101, 32'hdead_0001);
    for (int c = 0; c < 14; c++) begin
      smp();
      if (gnt[1]) b1++;
      if (pb_en && pb_addr == 10'h101) b2++;
      if (gnt[0] && req[0]) n0++;
      drv();
      if (c == 1) req[1] = 1'b0;
      if (n0 == MAX_BURST) req[0] = 1'b0;
    end
    n_checks += 2;
    if (b1 != 0 || b2 != 0) begin
      n_fail++;
      $display("FAIL drop_no_beat: got %0d grants %0d beats required 0 0", b1, b2);
    end
    if (n0 != MAX_BURST) begin
      n_fail++;
      $display("FAIL drop_owner_beats: got %0d required %0d", n0, MAX_BURST);
    end
  endtask

  task automatic test_reset_mid_read();
    int g = -1;
    int nrv = 0;
    set_req(3, 1'b1, 1'b0, 10'h002, 32'h0);
    for (int c = 0; c < 10 && g < 0; c++) begin
      smp();
      if (gnt[3] && req[3]) g = c;
      else drv();
    end
    drv();
    req[3] = 1'b0;
    rst = 1'b1;
    smp();
    n_checks += 3;
    if (g < 0) begin
      n_fail++;
      $display("FAIL midrst_grant: got no grant required grant within 10 cycles");
    end
    if ({gnt, rvalid, rdata, pb_en, pb_we, pb_addr, pb_din} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got gnt=%b rv=%b rd=%h en=%b we=%h a=%h d=%h required all 0",
               gnt, rvalid, rdata, pb_en, pb_we, pb_addr, pb_din);
    end
    drv();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      smp();
      if (rvalid !== 4'b0) nrv++;
      drv();
    end
    if (nrv != 0) begin
      n_fail++;
      $display("FAIL midrst_no_rvalid: got %0d pulses required 0", nrv);
    end
  endtask

  task automatic test_random();
    int          q_due [$];
    int          q_tag [$];
    logic [31:0] q_dat [$];
    logic [3:0]  acc, acc_prev, exp_rv;
    logic [31:0] exp_rd;
    logic        p_en;
    logic [3:0]  p_we;
    logic [9:0]  p_addr;
    logic [31:0] p_din;
    int          run = 0;
    int          oi;
    do_reset();
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    acc_prev = '0;
    p_en = 1'b0; p_we = '0; p_addr = '0; p_din = '0;
    for (int c = 0; c < 800; c++) begin
      smp();
      n_checks++;
      if (pb_en !== p_en ||
          (p_en && {pb_we, pb_addr, pb_din} !== {p_we, p_addr, p_din})) begin
        n_fail++;
        $display("FAIL rnd_portb c%0d: got %b %h %h %h required %b %h %h %h",
                 c, pb_en, pb_we, pb_addr, pb_din, p_en, p_we, p_addr, p_din);
      end
      exp_rv = '0;
      exp_rd = '0;
      if (q_due.size() > 0 && q_due[0] == c) begin
        exp_rv = 4'b0001 << q_tag[0];
        exp_rd = q_dat[0];
        void'(q_due.pop_front());
        void'(q_tag.pop_front());
        void'(q_dat.pop_front());
      end
      n_checks++;
      if (rvalid !== exp_rv || (exp_rv != 0 && rdata !== exp_rd)) begin
        n_fail++;
        $display("FAIL rnd_read c%0d: got %b %h required %b %h",
                 c, rvalid, rdata, exp_rv, exp_rd);
      end
      acc = gnt & req;
      run = (acc != 0 && acc == acc_prev) ? run + 1 : ((acc != 0) ? 1 : 0);
      n_checks++;
      if ((gnt & ~req) != 0 || $countones(gnt) > 1 ||
          (acc != 0 && acc_prev != 0 && acc != acc_prev) || run > MAX_BURST) begin
        n_fail++;
        $display("FAIL rnd_grant c%0d: got gnt=%b prev=%b req=%b run=%0d required legal grant",
                 c, gnt, acc_prev, req, run);
      end
      p_en = (acc != 0);
      if (acc != 0) begin
        oi = 0;
        for (int i = 0; i < NREQ; i++) if (acc[i]) oi = i;
        p_we   = req_we[oi] ? 4'hF : 4'h0;
        p_addr = req_addr[oi*10+:10];
        p_din  = req_wdata[oi*32+:32];
        if (req_we[oi]) ref_mem[p_addr] = p_din;
        else begin
          q_due.push_back(c + 1 + RD_LAT);
          q_tag.push_back(oi);
          q_dat.push_back(ref_mem[p_addr]);
        end
      end
      acc_prev = acc;
      drv();
      for (int i = 0; i < NREQ; i++) begin
        if (c >= 790) req[i] = 1'b0;
        else if (req[i]) begin
          if (acc[i]) begin
            if ($urandom_range(0, 9) < 6)
              set_req(i, 1'b1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom);
            else req[i] = 1'b0;
          end else if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 3)
          set_req(i, 1'b1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom);
      end
    end
    n_checks++;
    if (q_due.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_drain: got %0d reads outstanding required 0", q_due.size());
    end
  endtask

`ifdef BRAM_ARB_STATS_EN
  task automatic test_stats();
    int n = 0;
    do_reset();
    set_req(1, 1'b1, 1'b1, 10'h3ff, 32'h5a5a_0001);
    for (int c = 0; c < 20; c++) begin
      smp();
      if (gnt[1] && req[1]) n++;
      drv();
      if (n == 3) req[1] = 1'b0;
    end
    stat_sel = 3'd1;
    #1;
    n_checks++;
    if (stat_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL stats_req1: got %0d required 3", stat_cnt);
    end
    stat_sel = 3'd0;
    #1;
    n_checks++;
    if (stat_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_req0: got %0d required 0", stat_cnt);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_single_write();
    test_read_latency();
    test_round_robin();
    test_back_to_back();
    test_drop();
    test_reset_mid_read();
    test_random();
`ifdef BRAM_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
